bank_cmd_scheduler: RTL

// - Open-page command scheduler for one bank: turns host read/write requests into held ACT/RD/WR/PR/REF levels
//   for the bank timing FSM, and uses its 5-bit state output as command acknowledge.
// - Tracks the open row, inserts PR on row miss and runs periodic refresh from an internal tREFI timer.

---
 rtl/bank_cmd_scheduler_if.sv | 26 ++
 rtl/bank_cmd_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_scheduler_if.sv
// Host request/response bundle for bank_cmd_scheduler.
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; req_we/req_row/req_col must be stable while
// req_valid is high. resp_valid is a single-cycle completion pulse with no
// back-pressure.
interface bank_cmd_scheduler_if #(
    parameter int ROW_W = 14,
    parameter int COL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic             resp_valid;

    modport master (
        output req_valid, req_we, req_row, req_col,
        input  req_ready, resp_valid
    );

    modport slave (
        input  req_valid, req_we, req_row, req_col,
        output req_ready, resp_valid
    );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// Open-page command scheduler for a single bank. Converts host requests into
// held ACT/RD/WR/PR/REF levels and treats the timing FSM's bank_state as the
// acknowledge for each level. Tracks the open row, precharges on a row miss
// and services periodic refresh from an internal tREFI counter.
// Optional watchdog: define BANK_CMD_TMO_EN to bound every issue/drain wait
// to TMO cycles (sticky sched_err, forced return to CLOSED).
module bank_cmd_scheduler #(
    parameter int ROW_W = 14,
    parameter int COL_W = 10,
    parameter int TMO   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    bank_cmd_scheduler_if.slave host,
    input  logic [15:0]      refi,
    input  logic [4:0]       bank_state,
    output logic             ACT,
    output logic             RD,
    output logic             WR,
    output logic             PR,
    output logic             REF,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    output logic             ref_overrun,
    output logic             sched_err,
    output logic [3:0]       state_dbg,
    output logic             row_open_dbg,
    output logic [ROW_W-1:0] open_row_dbg,
    output logic             ref_pend_dbg
);
    localparam logic [4:0] BS_IDLE    = 5'd0;
    localparam logic [4:0] BS_ACTIVE  = 5'd3;
    localparam logic [4:0] BS_PRECHG  = 5'd10;
    localparam logic [4:0] BS_READING = 5'd11;
    localparam logic [4:0] BS_REFRESH = 5'd13;
    localparam logic [4:0] BS_WRITING = 5'd18;

    typedef enum logic [3:0] {
        CLOSED = 4'd0, ACT_I = 4'd1, ACT_W = 4'd2, OPEN  = 4'd3, RW_I  = 4'd4,
        RW_W   = 4'd5, PRE_I = 4'd6, PRE_W = 4'd7, REF_I = 4'd8, REF_W = 4'd9
    } state_t;

    state_t           state, state_next;
    logic             lat_we, req_pend, row_open, ref_pend;
    logic [ROW_W-1:0] open_row;
    logic [15:0]      refi_ct;
    logic             accept, miss, issue_pend, act_done, pre_done, ref_ack;
    logic             ready_c, resp_c, wrap, wd_trip;

    // Next-state and per-cycle event decode; the watchdog overrides last.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        resp_c     = 1'b0;
        accept     = 1'b0;
        miss       = 1'b0;
        issue_pend = 1'b0;
        act_done   = 1'b0;
        pre_done   = 1'b0;
        ref_ack    = 1'b0;
        case (state)
            CLOSED: begin
                if (ref_pend) begin
                    state_next = REF_I;
                end else begin
                    ready_c = 1'b1;
                    if (host.req_valid) begin
                        accept     = 1'b1;
                        miss       = 1'b1;
                        state_next = ACT_I;
                    end
                end
            end
            ACT_I: if (bank_state == BS_ACTIVE) begin
                act_done   = 1'b1;
                state_next = OPEN;
            end
            ACT_W: state_next = OPEN;
            OPEN: begin
                // A request latched before the ACT is finished ahead of refresh.
                if (req_pend) begin
                    issue_pend = 1'b1;
                    state_next = RW_I;
                end else if (ref_pend) begin
                    state_next = PRE_I;
                end else begin
                    ready_c = 1'b1;
                    if (host.req_valid) begin
                        accept = 1'b1;
                        if (row_open && host.req_row == open_row) begin
                            state_next = RW_I;
                        end else begin
                            miss       = 1'b1;
                            state_next = PRE_I;
                        end
                    end
                end
            end
            RW_I: if (bank_state == (lat_we ? BS_WRITING : BS_READING)) state_next = RW_W;
            RW_W: if (bank_state == BS_ACTIVE) begin
                resp_c     = 1'b1;
                state_next = OPEN;
            end
            PRE_I: if (bank_state == BS_PRECHG) state_next = PRE_W;
            PRE_W: if (bank_state == BS_IDLE) begin
                pre_done = 1'b1;
                if (req_pend)      state_next = ACT_I;
                else if (ref_pend) state_next = REF_I;
                else               state_next = CLOSED;
            end
            REF_I: if (bank_state == BS_REFRESH) begin
                ref_ack    = 1'b1;
                state_next = REF_W;
            end
            REF_W: if (bank_state == BS_IDLE) state_next = CLOSED;
            default: state_next = CLOSED;
        endcase
        if (wd_trip) begin
            state_next = CLOSED;
            resp_c     = 1'b0;
            act_done   = 1'b0;
            pre_done   = 1'b0;
            ref_ack    = 1'b0;
        end
    end

    // State register plus request latch and open-row tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLOSED;
            lat_we   <= 1'b0;
            cmd_row  <= '0;
            cmd_col  <= '0;
            req_pend <= 1'b0;
            row_open <= 1'b0;
            open_row <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we  <= host.req_we;
                cmd_row <= host.req_row;
                cmd_col <= host.req_col;
            end
            if (accept && miss) req_pend <= 1'b1;
            if (issue_pend)     req_pend <= 1'b0;
            if (act_done) begin
                row_open <= 1'b1;
                open_row <= cmd_row;
            end
            if (pre_done) row_open <= 1'b0;
            if (wd_trip) begin
                row_open <= 1'b0;
                req_pend <= 1'b0;
            end
        end
    end

    // tREFI timer: wraps at refi-1, raising a refresh request (or overrun).
    assign wrap = (refi != 16'd0) && (refi_ct >= refi - 16'd1);

    // Refresh counter, pending flag and overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi_ct     <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (refi == 16'd0 || wrap) refi_ct <= '0;
            else                       refi_ct <= refi_ct + 16'd1;
            if (wrap)         ref_pend <= 1'b1;
            else if (ref_ack) ref_pend <= 1'b0;
            ref_overrun <= wrap && ref_pend;
        end
    end

`ifdef BANK_CMD_TMO_EN
    localparam int WD_W = $clog2(TMO + 1);
    logic [WD_W-1:0] wd_ct;
    logic            in_wait;

    assign in_wait = (state != CLOSED) && (state != OPEN);
    assign wd_trip = in_wait && (wd_ct == WD_W'(TMO - 1));

    // Watchdog: cycles in the current issue/drain state, sticky error on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_ct     <= '0;
            sched_err <= 1'b0;
        end else begin
            if (!in_wait || state_next != state) wd_ct <= '0;
            else                                 wd_ct <= wd_ct + WD_W'(1);
            if (wd_trip) sched_err <= 1'b1;
        end
    end
`else
    wire unused_tmo = (TMO == 0);
    assign wd_trip   = 1'b0;
    assign sched_err = 1'b0;
`endif

    assign host.req_ready  = ready_c && rst_n;
    assign host.resp_valid = resp_c;
    assign ACT             = (state == ACT_I);
    assign RD              = (state == RW_I) && !lat_we;
    assign WR              = (state == RW_I) && lat_we;
    assign PR              = (state == PRE_I);
    assign REF             = (state == REF_I);
    assign state_dbg       = state;
    assign row_open_dbg    = row_open;
    assign open_row_dbg    = open_row;
    assign ref_pend_dbg    = ref_pend;
endmodule
